// File: rtl/fft8_p2s_unload_if.sv
// rtl/fft8_p2s_unload_if.sv - frame input and serial sample output bundle of the FFT unloader
//
// Frame side: eight complex lanes i_data{0..7}_{r,i} with i_valid/o_ready.
// Sample side: o_data_r/o_data_i/o_index/o_last with o_valid/i_ready.
// Signal prefixes are from the unloader's point of view.
// slave  : the unloader itself
// master : the producer/consumer environment around it
// NB_INPUT/NB_OUTPUT must match the parameters of the unloader instance.
interface fft8_p2s_unload_if #(
    parameter int NB_INPUT  = 12,
    parameter int NB_OUTPUT = 10
);
    logic signed [NB_INPUT-1:0]  i_data0_r, i_data1_r, i_data2_r, i_data3_r;
    logic signed [NB_INPUT-1:0]  i_data4_r, i_data5_r, i_data6_r, i_data7_r;
    logic signed [NB_INPUT-1:0]  i_data0_i, i_data1_i, i_data2_i, i_data3_i;
    logic signed [NB_INPUT-1:0]  i_data4_i, i_data5_i, i_data6_i, i_data7_i;
    logic                        i_valid;
    logic                        o_ready;
    logic signed [NB_OUTPUT-1:0] o_data_r;
    logic signed [NB_OUTPUT-1:0] o_data_i;
    logic [2:0]                  o_index;
    logic                        o_last;
    logic                        o_valid;
    logic                        i_ready;

    modport slave (
        input  i_data0_r, i_data1_r, i_data2_r, i_data3_r,
        input  i_data4_r, i_data5_r, i_data6_r, i_data7_r,
        input  i_data0_i, i_data1_i, i_data2_i, i_data3_i,
        input  i_data4_i, i_data5_i, i_data6_i, i_data7_i,
        input  i_valid, i_ready,
        output o_ready, o_data_r, o_data_i, o_index, o_last, o_valid
    );

    modport master (
        output i_data0_r, i_data1_r, i_data2_r, i_data3_r,
        output i_data4_r, i_data5_r, i_data6_r, i_data7_r,
        output i_data0_i, i_data1_i, i_data2_i, i_data3_i,
        output i_data4_i, i_data5_i, i_data6_i, i_data7_i,
        output i_valid, i_ready,
        input  o_ready, o_data_r, o_data_i, o_index, o_last, o_valid
    );
endinterface

// File: rtl/fft8_p2s_unload.sv
// rtl/fft8_p2s_unload.sv - double-buffered parallel-to-serial unloader for the 8-point FFT
//
// Captures a frame of eight complex lanes in one cycle, then streams it out one
// sample per cycle in natural frequency order, rounded and saturated.
// Ports:
//   i_clock : system clock, all state on the rising edge
//   i_reset : synchronous active-high reset of the control state
//   bus     : fft8_p2s_unload_if.slave (frame in, sample stream out)
// Parameters:
//   NB_INPUT  : signed lane width
//   NB_OUTPUT : signed output width (NB_OUTPUT <= NB_INPUT + 1)
//   SHIFT     : rounding right-shift before saturation (0..NB_INPUT-1)
//   BIT_REV   : 1 = lanes arrive in bit-reversed order, 0 = natural order
module fft8_p2s_unload #(
    parameter int NB_INPUT  = 12,
    parameter int NB_OUTPUT = 10,
    parameter int SHIFT     = 2,
    parameter int BIT_REV   = 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    fft8_p2s_unload_if.slave        bus
);

    // Saturation bounds and the half-LSB rounding constant, all at the
    // one-bit-wider intermediate width so the rounding add cannot overflow.
    localparam logic signed [NB_INPUT:0] OUT_MAX =
        {{(NB_INPUT + 2 - NB_OUTPUT){1'b0}}, {(NB_OUTPUT - 1){1'b1}}};
    localparam logic signed [NB_INPUT:0] OUT_MIN =
        {{(NB_INPUT + 2 - NB_OUTPUT){1'b1}}, {(NB_OUTPUT - 1){1'b0}}};
    // (1 << SHIFT) >> 1 is 2^(SHIFT-1) for SHIFT > 0 and 0 for SHIFT == 0,
    // so a single expression covers both cases.
    localparam logic signed [NB_INPUT:0] RND = (NB_INPUT + 1)'((1 << SHIFT) >> 1);

    // Fill level of the two banks; EMPTY/ONE/FULL is the frame count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_e;

    fill_e      state, state_nxt;
    logic [2:0] rd_cnt, rd_cnt_nxt;
    logic       wr_bank, wr_bank_nxt;
    logic       rd_bank, rd_bank_nxt;

    logic signed [NB_INPUT-1:0] lane_r [8];
    logic signed [NB_INPUT-1:0] lane_i [8];
    logic signed [NB_INPUT-1:0] bank_r [2][8];
    logic signed [NB_INPUT-1:0] bank_i [2][8];

    logic       accept;
    logic       xfer;
    logic       last_xfer;
    logic [2:0] rd_lane;

    function automatic logic signed [NB_OUTPUT-1:0] scale(input logic signed [NB_INPUT-1:0] x);
        logic signed [NB_INPUT:0] t;
        t = ($signed({x[NB_INPUT-1], x}) + RND) >>> SHIFT;
        if (t > OUT_MAX) begin
            return OUT_MAX[NB_OUTPUT-1:0];
        end else if (t < OUT_MIN) begin
            return OUT_MIN[NB_OUTPUT-1:0];
        end
        return t[NB_OUTPUT-1:0];
    endfunction

    always_comb begin
        lane_r[0] = bus.i_data0_r;
        lane_r[1] = bus.i_data1_r;
        lane_r[2] = bus.i_data2_r;
        lane_r[3] = bus.i_data3_r;
        lane_r[4] = bus.i_data4_r;
        lane_r[5] = bus.i_data5_r;
        lane_r[6] = bus.i_data6_r;
        lane_r[7] = bus.i_data7_r;
        lane_i[0] = bus.i_data0_i;
        lane_i[1] = bus.i_data1_i;
        lane_i[2] = bus.i_data2_i;
        lane_i[3] = bus.i_data3_i;
        lane_i[4] = bus.i_data4_i;
        lane_i[5] = bus.i_data5_i;
        lane_i[6] = bus.i_data6_i;
        lane_i[7] = bus.i_data7_i;
    end

    // o_ready is the only output that sees an input combinationally: it is
    // forced low while reset is asserted so no frame is captured then.
    assign bus.o_ready = (state != FULL) && !i_reset;
    assign bus.o_valid = (state != EMPTY);
    assign bus.o_index = rd_cnt;
    assign bus.o_last  = bus.o_valid && (rd_cnt == 3'd7);

    assign accept    = bus.i_valid && bus.o_ready;
    assign xfer      = bus.o_valid && bus.i_ready;
    assign last_xfer = xfer && (rd_cnt == 3'd7);

    // Natural-order index k lives in lane bitrev3(k) when the butterflies
    // emit bit-reversed lanes.
    assign rd_lane = (BIT_REV != 0) ? {rd_cnt[0], rd_cnt[1], rd_cnt[2]} : rd_cnt;

    assign bus.o_data_r = scale(bank_r[rd_bank][rd_lane]);
    assign bus.o_data_i = scale(bank_i[rd_bank][rd_lane]);

    // Frame storage carries no reset; contents are only observed while valid.
    always_ff @(posedge i_clock) begin
        if (accept) begin
            for (int n = 0; n < 8; n++) begin
                bank_r[wr_bank][n] <= lane_r[n];
                bank_i[wr_bank][n] <= lane_i[n];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= EMPTY;
            rd_cnt  <= 3'd0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_cnt  <= rd_cnt_nxt;
            wr_bank <= wr_bank_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_cnt_nxt  = rd_cnt;
        wr_bank_nxt = wr_bank;
        rd_bank_nxt = rd_bank;

        if (accept) begin
            wr_bank_nxt = ~wr_bank;
        end
        if (xfer) begin
            rd_cnt_nxt = rd_cnt + 3'd1;
        end
        if (last_xfer) begin
            rd_bank_nxt = ~rd_bank;
        end

        // A capture and a frame completion in the same cycle cancel out,
        // which is what keeps the stream gap-free at one frame per 8 cycles.
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && !last_xfer) begin
                    state_nxt = FULL;
                end else if (!accept && last_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (last_xfer) begin
                    state_nxt = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_fft8_p2s_unload.sv
// tb/tb_fft8_p2s_unload.sv - self-checking bench for fft8_p2s_unload against a frame-queue model
module tb_fft8_p2s_unload;

    localparam int NBI = 12;
    localparam int NBO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft8_p2s_unload_if #(.NB_INPUT(NBI), .NB_OUTPUT(NBO)) bus ();
    fft8_p2s_unload_if #(.NB_INPUT(NBI), .NB_OUTPUT(NBO)) bus0 ();

    fft8_p2s_unload #(.NB_INPUT(NBI), .NB_OUTPUT(NBO), .SHIFT(2), .BIT_REV(1)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    fft8_p2s_unload #(.NB_INPUT(NBI), .NB_OUTPUT(NBO), .SHIFT(0), .BIT_REV(0)) dut0 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus0)
    );

    typedef int frame_t [16];

    frame_t q[$];
    frame_t cur;
    int     k = 0;
    int     tests = 0;
    int     fails = 0;
    int     seen_r [8];
    int     valid_cnt;
    int     acc_dut;
    int     brev_tab  [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int     exp_order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int mscale(input int x, input int s);
        int d, n, t, hi, lo;
        d  = 1 << s;
        n  = x + d / 2;
        t  = (n >= 0) ? n / d : -((-n + d - 1) / d);
        hi = (1 << (NBO - 1)) - 1;
        lo = -(1 << (NBO - 1));
        if (t > hi) t = hi;
        if (t < lo) t = lo;
        return t;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rand_frame();
        for (int j = 0; j < 16; j++) cur[j] = int'($urandom_range(4095)) - 2048;
    endtask

    task automatic drive();
        bus.i_data0_r = NBI'(cur[0]);  bus0.i_data0_r = NBI'(cur[0]);
        bus.i_data1_r = NBI'(cur[1]);  bus0.i_data1_r = NBI'(cur[1]);
        bus.i_data2_r = NBI'(cur[2]);  bus0.i_data2_r = NBI'(cur[2]);
        bus.i_data3_r = NBI'(cur[3]);  bus0.i_data3_r = NBI'(cur[3]);
        bus.i_data4_r = NBI'(cur[4]);  bus0.i_data4_r = NBI'(cur[4]);
        bus.i_data5_r = NBI'(cur[5]);  bus0.i_data5_r = NBI'(cur[5]);
        bus.i_data6_r = NBI'(cur[6]);  bus0.i_data6_r = NBI'(cur[6]);
        bus.i_data7_r = NBI'(cur[7]);  bus0.i_data7_r = NBI'(cur[7]);
        bus.i_data0_i = NBI'(cur[8]);  bus0.i_data0_i = NBI'(cur[8]);
        bus.i_data1_i = NBI'(cur[9]);  bus0.i_data1_i = NBI'(cur[9]);
        bus.i_data2_i = NBI'(cur[10]); bus0.i_data2_i = NBI'(cur[10]);
        bus.i_data3_i = NBI'(cur[11]); bus0.i_data3_i = NBI'(cur[11]);
        bus.i_data4_i = NBI'(cur[12]); bus0.i_data4_i = NBI'(cur[12]);
        bus.i_data5_i = NBI'(cur[13]); bus0.i_data5_i = NBI'(cur[13]);
        bus.i_data6_i = NBI'(cur[14]); bus0.i_data6_i = NBI'(cur[14]);
        bus.i_data7_i = NBI'(cur[15]); bus0.i_data7_i = NBI'(cur[15]);
    endtask

    // One clock cycle: drive, compare outputs at the falling edge against the
    // frame queue, then advance the queue model across the rising edge.
    task automatic cycle(input bit v, input bit rdy, input bit rs);
        bit ev, er, acc, xf;
        int ln;
        drive();
        bus.i_valid = v;   bus0.i_valid = v;
        bus.i_ready = rdy; bus0.i_ready = rdy;
        rst = rs;
        @(negedge clk);
        ev = (q.size() != 0);
        er = (q.size() != 2) && !rs;
        check("o_ready", bus.o_ready, er);
        check("o_valid", bus.o_valid, ev);
        check("o_index", bus.o_index, k);
        check("o_last", bus.o_last, ev && (k == 7));
        check("o_valid_nat", bus0.o_valid, ev);
        if (ev) begin
            ln = brev_tab[k];
            check("o_data_r", bus.o_data_r, mscale(q[0][ln], 2));
            check("o_data_i", bus.o_data_i, mscale(q[0][8 + ln], 2));
            check("o_data_r_nat", bus0.o_data_r, mscale(q[0][k], 0));
            check("o_data_i_nat", bus0.o_data_i, mscale(q[0][8 + k], 0));
            seen_r[k] = int'(bus.o_data_r);
        end
        if (bus.o_valid) valid_cnt++;
        if (v && bus.o_ready) acc_dut++;
        acc = v && er;
        xf  = ev && rdy;
        @(posedge clk);
        if (rs) begin
            q.delete();
            k = 0;
        end else begin
            if (xf) begin
                if (k == 7) begin
                    void'(q.pop_front());
                    k = 0;
                end else begin
                    k++;
                end
            end
            if (acc) q.push_back(cur);
        end
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 20; c++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rand_frame();

        // Reset state
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);

        // Natural-order unloading of a ramp frame (scaled by 4 then shifted back)
        for (int n = 0; n < 8; n++) begin
            cur[n]     = 4 * n;
            cur[8 + n] = -4 * n;
        end
        cycle(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 9; c++) cycle(1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 8; n++) check("order", seen_r[n], exp_order[n]);

        // Back-to-back frames every 8 cycles: 32 contiguous samples
        valid_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            cycle(1'b1, 1'b1, 1'b0);
            for (int c = 0; c < 7; c++) cycle(1'b0, 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("b2b_valid_cycles", valid_cnt, 32);

        // Backpressure with both banks filling
        acc_dut = 0;
        for (int c = 0; c < 20; c++) begin
            rand_frame();
            cycle(1'b1, 1'b0, 1'b0);
        end
        check("bp_accepts", acc_dut, 2);
        for (int c = 0; c < 24; c++) begin
            rand_frame();
            cycle(1'b1, 1'b1, 1'b0);
        end
        drain();

        // Rounding and saturation corner values
        rand_frame();
        for (int n = 4; n < 8; n++) cur[n] = 0;
        cur[0] = 13;
        cur[1] = 2047;
        cur[2] = -2048;
        cur[3] = -6;
        cycle(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 9; c++) cycle(1'b0, 1'b1, 1'b0);
        check("scale_13", seen_r[0], 3);
        check("scale_2047", seen_r[4], 511);
        check("scale_m2048", seen_r[2], -512);
        check("scale_m6", seen_r[6], -1);

        // Capture on the very cycle the last sample of the only frame leaves
        rand_frame();
        cycle(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 7; c++) cycle(1'b0, 1'b1, 1'b0);
        rand_frame();
        cycle(1'b1, 1'b1, 1'b0);
        bus.i_valid = 1'b0; bus0.i_valid = 1'b0;
        #1;
        check("simul_valid", bus.o_valid, 1);
        check("simul_index", bus.o_index, 0);
        check("simul_ready", bus.o_ready, 1);
        check("simul_data_r", bus.o_data_r, mscale(cur[0], 2));
        drain();

        // Reset mid-frame with a second frame buffered
        rand_frame();
        cycle(1'b1, 1'b1, 1'b0);
        rand_frame();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("pre_reset_index", bus.o_index, 3);
        cycle(1'b0, 1'b1, 1'b1);
        check("post_reset_valid", bus.o_valid, 0);
        rst = 1'b0;
        #1;
        check("post_reset_ready", bus.o_ready, 1);
        rand_frame();
        cycle(1'b1, 1'b1, 1'b0);
        drain();

        // Randomized traffic, backpressure and occasional reset
        for (int c = 0; c < 400; c++) begin
            rand_frame();
            cycle(bit'($urandom_range(1)), ($urandom_range(3) != 0), ($urandom_range(199) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
